apb_timer: RTL
==============

APB_TIMER -- requirements
Module: apb_timer

Interface
REQ-001 HCLK  input  1  sole clock; all state changes on rising edge.
REQ-002 HRESET  input  1  reset; synchronous, active-high.
REQ-003 PSEL  input  1  APB select from the AHB-to-APB bridge.
REQ-004 PENABLE  input  1  APB access phase indicator.
REQ-005 PWRITE  input  1  1 = write, 0 = read.
REQ-006 PADDR  input  32  byte address; PADDR[11:0] decoded, PADDR[31:12] ignored.
REQ-007 PWDATA  input  32  write data.
REQ-008 PRDATA  output  32  registered read data to the bridge.
REQ-009 IRQ  output  1  timer interrupt, active-high level.

Function
REQ-010 Register map SHALL be: 0x000 CTRL (RW; [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN, [31:3] read 0); 0x004 LOAD (RW, 32 bits); 0x008 VALUE (RO); 0x00C STATUS (bit [0] EXPIRED, write-1-to-clear, [31:1] read 0).
REQ-011 Any other offset SHALL read 0x0000_0000 and ignore writes; writes to VALUE SHALL be ignored.
REQ-012 APB protocol SHALL be APB2 with no wait states: setup phase = PSEL & !PENABLE; access phase = PSEL & PENABLE; every transfer completes in 2 cycles.
REQ-013 A register write SHALL commit at the rising edge that ends the access phase (PSEL & PENABLE & PWRITE).
REQ-014 On a setup-phase read (PSEL & !PENABLE & !PWRITE), PRDATA SHALL be loaded with the addressed register value at that edge and SHALL hold through the access phase.
REQ-015 PRDATA SHALL hold its last value when no read setup phase occurs.
REQ-016 When EN=1 and VALUE!=0, VALUE SHALL decrement by 1 on each cycle.
REQ-017 When EN=1 and VALUE==0: EXPIRED SHALL be set; if AUTO_RELOAD=1, VALUE SHALL load LOAD; otherwise EN SHALL clear and VALUE SHALL stay 0.
REQ-018 Periodic mode with LOAD=N SHALL expire every N+1 cycles.
REQ-019 LOAD=0 with AUTO_RELOAD=1 SHALL expire every cycle.
REQ-020 When EN=0, VALUE SHALL hold.
REQ-021 Setting EN 0->1 SHALL NOT reload; counting SHALL resume from the current VALUE.
REQ-022 A write to LOAD SHALL also set VALUE to PWDATA at the same edge.
REQ-023 A LOAD write SHALL take priority over a decrement or reload in the same cycle.
REQ-024 A CTRL write setting EN=1 in the same cycle as a one-shot expiry SHALL win: EN remains 1.
REQ-025 Writing STATUS with PWDATA[0]=1 SHALL clear EXPIRED; writing 0 SHALL have no effect.
REQ-026 If an expiry and a STATUS clear fall in the same cycle, set SHALL win: EXPIRED=1.
REQ-027 IRQ SHALL equal EXPIRED & IRQ_EN, formed only from flop outputs.
REQ-028 A read of VALUE SHALL return the value held at the setup-phase edge, not the access-phase value.
REQ-029 Arithmetic SHALL be unsigned 32-bit; VALUE SHALL never underflow below 0.

Reset
REQ-030 While HRESET=1 at a rising edge, the following SHALL all be set to 0: CTRL, LOAD, VALUE, EXPIRED and PRDATA. IRQ SHALL therefore be 0.
REQ-031 Reset asserted mid-transfer or mid-count SHALL abort all activity; the first transfer after reset deasserts SHALL decode normally.
REQ-032 APB inputs SHALL be ignored in any cycle where HRESET=1.

Verification
REQ-033 Register access: write LOAD=0x0000_0010, then read 0x004 and 0x008 -> both return 0x0000_0010; read 0x010 -> 0x0000_0000.
REQ-034 One-shot mode: LOAD=3, write CTRL=0x5 -> VALUE counts 3,2,1,0; EXPIRED=1 and IRQ=1 on the following edge; EN reads 0; VALUE stays 0.
REQ-035 Periodic mode: LOAD=2, CTRL=0x3 -> EXPIRED sets every 3 cycles; IRQ stays 0 (IRQ_EN=0); writing STATUS=0x1 clears EXPIRED.
REQ-036 Collision cases:
- STATUS clear in the same cycle as an expiry -> EXPIRED stays 1.
- LOAD=0x20 written while VALUE==0 in periodic mode -> VALUE=0x20, not the old LOAD.
REQ-037 Reset mid-count: assert HRESET for 1 cycle with VALUE=5 and EN=1 -> all registers, PRDATA and IRQ read 0; no further decrement.
REQ-038 Back-to-back reads of VALUE while counting from 0x100 -> returned values differ by exactly 2, matching the setup-phase sample.

Source files
------------

// File: rtl/apb_timer.sv
// apb_timer: APB2 slave wrapping a 32-bit down-counter.
// The counter supports one-shot and auto-reload modes, has a sticky
// EXPIRED flag and a level interrupt.
//
// Bus handshake: APB2 without wait states. A transfer has a setup phase
// (PSEL & !PENABLE) followed by exactly one access phase
// (PSEL & PENABLE). The slave is always ready. Writes commit at the edge
// that ends the access phase. Reads capture the addressed register into
// PRDATA at the edge that ends the setup phase, and PRDATA then holds
// until the next read setup phase.
module apb_timer (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        IRQ
);

    localparam logic [11:0] OFF_CTRL   = 12'h000;
    localparam logic [11:0] OFF_LOAD   = 12'h004;
    localparam logic [11:0] OFF_VALUE  = 12'h008;
    localparam logic [11:0] OFF_STATUS = 12'h00C;

    logic [11:0] addr;
    logic        wr_access;
    logic        rd_setup;
    logic        wr_ctrl;
    logic        wr_load;
    logic        wr_status;

    logic        ctrl_en;
    logic        ctrl_auto;
    logic        ctrl_irq_en;
    logic [31:0] load_q;
    logic [31:0] value_q;
    logic        expired_q;
    logic [31:0] prdata_q;

    logic        expire;
    logic        en_nxt;
    logic [31:0] value_nxt;
    logic        expired_nxt;
    logic [31:0] rd_data;

    // Upper address bits are outside this block's 4 KB window.
    logic        unused_addr;
    assign unused_addr = &{1'b0, PADDR[31:12]};

    assign addr = PADDR[11:0];

    // Decode bus phases and per-register write strobes.
    always_comb begin
        wr_access = PSEL & PENABLE & PWRITE;
        rd_setup  = PSEL & ~PENABLE & ~PWRITE;
        wr_ctrl   = wr_access & (addr == OFF_CTRL);
        wr_load   = wr_access & (addr == OFF_LOAD);
        wr_status = wr_access & (addr == OFF_STATUS);
    end

    // Counter next state: bus writes are applied last so they override
    // the free-running behaviour in the same cycle, except that an expiry
    // always beats a STATUS clear.
    always_comb begin
        expire      = ctrl_en & (value_q == 32'd0);
        en_nxt      = ctrl_en;
        value_nxt   = value_q;
        expired_nxt = expired_q;

        if (ctrl_en) begin
            if (value_q != 32'd0) begin
                value_nxt = value_q - 32'd1;
            end else if (ctrl_auto) begin
                value_nxt = load_q;
            end else begin
                value_nxt = 32'd0;
                en_nxt    = 1'b0;
            end
        end

        if (wr_ctrl) begin
            en_nxt = PWDATA[0];
        end
        if (wr_load) begin
            value_nxt = PWDATA;
        end

        if (wr_status && PWDATA[0]) begin
            expired_nxt = 1'b0;
        end
        if (expire) begin
            expired_nxt = 1'b1;
        end
    end

    // Read mux; unmapped offsets return zero.
    always_comb begin
        rd_data = 32'd0;
        case (addr)
            OFF_CTRL:   rd_data = {29'd0, ctrl_irq_en, ctrl_auto, ctrl_en};
            OFF_LOAD:   rd_data = load_q;
            OFF_VALUE:  rd_data = value_q;
            OFF_STATUS: rd_data = {31'd0, expired_q};
            default:    rd_data = 32'd0;
        endcase
    end

    // Control and reload registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ctrl_en     <= 1'b0;
            ctrl_auto   <= 1'b0;
            ctrl_irq_en <= 1'b0;
            load_q      <= 32'd0;
        end else begin
            ctrl_en <= en_nxt;
            if (wr_ctrl) begin
                ctrl_auto   <= PWDATA[1];
                ctrl_irq_en <= PWDATA[2];
            end
            if (wr_load) begin
                load_q <= PWDATA;
            end
        end
    end

    // Counter value and sticky expiry flag.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            value_q   <= 32'd0;
            expired_q <= 1'b0;
        end else begin
            value_q   <= value_nxt;
            expired_q <= expired_nxt;
        end
    end

    // Read data is captured in the setup phase and held otherwise.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            prdata_q <= 32'd0;
        end else if (rd_setup) begin
            prdata_q <= rd_data;
        end
    end

    assign PRDATA = prdata_q;
    assign IRQ    = expired_q & ctrl_irq_en;

endmodule
